// File: rtl/int_ctrl.sv
// Interrupt controller: external/timer/serial flag capture, two-level priority
// arbitration, request/acknowledge handshake and in-service tracking.
module int_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int0_n,
    input  logic        int1_n,
    input  logic        it0,
    input  logic        it1,
    input  logic        t0_ovf,
    input  logic        t1_ovf,
    input  logic        ri,
    input  logic        ti,
    input  logic [7:0]  ie,
    input  logic [4:0]  ip,
    input  logic [3:0]  sw_clr,
    input  logic        instr_end,
    input  logic        int_ack,
    input  logic        reti,
    output logic        int_req,
    output logic [15:0] int_vec,
    output logic [3:0]  tcon_flags,
    output logic [1:0]  in_svc
);

    localparam int unsigned NSRC = 5;
    localparam int unsigned SW   = 3;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [1:0]      x0_sync, x1_sync;
    logic            x0_prev, x1_prev;
    logic            t0_q, t1_q, reti_q;
    logic            ie0_f, tf0_f, ie1_f, tf1_f;
    logic            ie0_nxt, tf0_nxt, ie1_nxt, tf1_nxt;
    logic [0:0]      state, state_nxt;
    logic [15:0]     vec_nxt;
    logic            lvl_q, lvl_nxt;
    logic [SW-1:0]   src_q, src_nxt;
    logic [1:0]      svc_nxt;
    logic            ack_c;
    logic [NSRC-1:0] ack_src, src_flags, pend, hi, lo;
    logic            win_ok, win_lvl;
    logic [SW-1:0]   win_src;
    logic            unused_ie;

    assign unused_ie  = ^ie[6:5];
    assign tcon_flags = {tf1_f, ie1_f, tf0_f, ie0_f};

    // Pin synchronizers plus previous-value registers for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_sync <= 2'b11;
            x1_sync <= 2'b11;
            x0_prev <= 1'b1;
            x1_prev <= 1'b1;
            t0_q    <= 1'b0;
            t1_q    <= 1'b0;
            reti_q  <= 1'b0;
        end else begin
            x0_sync <= {x0_sync[0], int0_n};
            x1_sync <= {x1_sync[0], int1_n};
            x0_prev <= x0_sync[1];
            x1_prev <= x1_sync[1];
            t0_q    <= t0_ovf;
            t1_q    <= t1_ovf;
            reti_q  <= reti;
        end
    end

    // Flag next-state: a set event always overrides a same-cycle clear
    always_comb begin
        ack_c   = (state == ST_REQ) && int_ack;
        ack_src = '0;
        if (ack_c) ack_src[src_q] = 1'b1;
        ie0_nxt = it0 ? ((x0_prev & ~x0_sync[1]) | (ie0_f & ~(ack_src[0] | sw_clr[0])))
                      : ~x0_sync[1];
        ie1_nxt = it1 ? ((x1_prev & ~x1_sync[1]) | (ie1_f & ~(ack_src[2] | sw_clr[2])))
                      : ~x1_sync[1];
        tf0_nxt = (t0_ovf & ~t0_q) | (tf0_f & ~(ack_src[1] | sw_clr[1]));
        tf1_nxt = (t1_ovf & ~t1_q) | (tf1_f & ~(ack_src[3] | sw_clr[3]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie0_f <= 1'b0;
            tf0_f <= 1'b0;
            ie1_f <= 1'b0;
            tf1_f <= 1'b0;
        end else begin
            ie0_f <= ie0_nxt;
            tf0_f <= tf0_nxt;
            ie1_f <= ie1_nxt;
            tf1_f <= tf1_nxt;
        end
    end

    // Arbitration: bit index equals fixed priority order, lowest index wins
    always_comb begin
        src_flags = {ri | ti, tf1_f, ie1_f, tf0_f, ie0_f};
        pend      = src_flags & ie[NSRC-1:0] & {NSRC{ie[7]}};
        hi        = pend & ip;
        lo        = pend & ~ip;
        win_ok    = 1'b0;
        win_lvl   = 1'b0;
        win_src   = '0;
        if ((|hi) && !in_svc[1]) begin
            win_ok  = 1'b1;
            win_lvl = 1'b1;
            for (int i = int'(NSRC) - 1; i >= 0; i--) begin
                if (hi[i]) win_src = SW'(i);
            end
        end else if ((|lo) && (in_svc == 2'b00)) begin
            win_ok = 1'b1;
            for (int i = int'(NSRC) - 1; i >= 0; i--) begin
                if (lo[i]) win_src = SW'(i);
            end
        end
    end

    // Request FSM and in-service stack next-state
    always_comb begin
        state_nxt = state;
        vec_nxt   = int_vec;
        lvl_nxt   = lvl_q;
        src_nxt   = src_q;
        svc_nxt   = in_svc;
        case (state)
            ST_IDLE: begin
                if (instr_end && win_ok && !reti && !reti_q) begin
                    state_nxt = ST_REQ;
                    vec_nxt   = {10'd0, win_src, 3'b011};
                    lvl_nxt   = win_lvl;
                    src_nxt   = win_src;
                end
            end
            ST_REQ: begin
                if (int_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reti) begin
            if (in_svc[1]) svc_nxt[1] = 1'b0;
            else           svc_nxt[0] = 1'b0;
        end
        if (ack_c) svc_nxt[lvl_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
            int_vec <= 16'h0000;
            lvl_q   <= 1'b0;
            src_q   <= '0;
            in_svc  <= 2'b00;
        end else begin
            state   <= state_nxt;
            int_req <= (state_nxt == ST_REQ);
            int_vec <= vec_nxt;
            lvl_q   <= lvl_nxt;
            src_q   <= src_nxt;
            in_svc  <= svc_nxt;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed table, corner sequences and randomized run
// compared against a cycle-level behavioural model.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int0_n, int1_n, it0, it1, t0_ovf, t1_ovf, ri, ti;
    logic [7:0]  ie;
    logic [4:0]  ip;
    logic [3:0]  sw_clr;
    logic        instr_end, int_ack, reti;
    logic        int_req;
    logic [15:0] int_vec;
    logic [3:0]  tcon_flags;
    logic [1:0]  in_svc;

    int n_pass = 0;
    int n_total = 0;

    int_ctrl dut (
        .clk(clk), .rst_n(rst_n), .int0_n(int0_n), .int1_n(int1_n),
        .it0(it0), .it1(it1), .t0_ovf(t0_ovf), .t1_ovf(t1_ovf),
        .ri(ri), .ti(ti), .ie(ie), .ip(ip), .sw_clr(sw_clr),
        .instr_end(instr_end), .int_ack(int_ack), .reti(reti),
        .int_req(int_req), .int_vec(int_vec), .tcon_flags(tcon_flags),
        .in_svc(in_svc)
    );

    always #5 clk = ~clk;

    // Behavioural model: sample histories (newest first) and source flags
    bit       q_p0[$], q_p1[$], q_t0[$], q_t1[$], q_rt[$];
    bit [3:0] m_flag;
    bit       m_req;
    int       m_vec, m_src, m_lvl;
    bit [1:0] m_svc;

    function automatic void m_reset();
        q_p0 = '{1'b1, 1'b1, 1'b1, 1'b1};
        q_p1 = '{1'b1, 1'b1, 1'b1, 1'b1};
        q_t0 = '{1'b0, 1'b0};
        q_t1 = '{1'b0, 1'b0};
        q_rt = '{1'b0, 1'b0};
        m_flag = 4'b0000;
        m_req = 1'b0;
        m_vec = 0;
        m_src = 0;
        m_lvl = 0;
        m_svc = 2'b00;
    endfunction

    function automatic void m_clock();
        bit [4:0] fl;
        bit [3:0] nf, ackh;
        bit [1:0] nsvc;
        bit       blk;
        int       win, wl;
        q_p0.push_front(int0_n); void'(q_p0.pop_back());
        q_p1.push_front(int1_n); void'(q_p1.pop_back());
        q_t0.push_front(t0_ovf); void'(q_t0.pop_back());
        q_t1.push_front(t1_ovf); void'(q_t1.pop_back());
        q_rt.push_front(reti);   void'(q_rt.pop_back());
        fl  = {ri | ti, m_flag};
        win = -1;
        wl  = 0;
        for (int lv = 1; lv >= 0; lv--) begin
            if (win < 0 && ((lv == 1 && !m_svc[1]) || (lv == 0 && m_svc == 2'b00))) begin
                for (int i = 0; i < 5; i++) begin
                    if (win < 0 && fl[i] && ie[i] && ie[7] && ((ip[i] ? 1 : 0) == lv)) begin
                        win = i;
                        wl  = lv;
                    end
                end
            end
        end
        ackh = 4'b0000;
        if (m_req && int_ack && m_src < 4) ackh[m_src] = 1'b1;
        nf[0] = it0 ? ((q_p0[3] && !q_p0[2]) || (m_flag[0] && !(ackh[0] || sw_clr[0]))) : !q_p0[2];
        nf[2] = it1 ? ((q_p1[3] && !q_p1[2]) || (m_flag[2] && !(ackh[2] || sw_clr[2]))) : !q_p1[2];
        nf[1] = (q_t0[0] && !q_t0[1]) || (m_flag[1] && !(ackh[1] || sw_clr[1]));
        nf[3] = (q_t1[0] && !q_t1[1]) || (m_flag[3] && !(ackh[3] || sw_clr[3]));
        blk  = q_rt[0] || q_rt[1];
        nsvc = m_svc;
        if (reti) begin
            if (nsvc[1]) nsvc[1] = 1'b0;
            else         nsvc[0] = 1'b0;
        end
        if (m_req) begin
            if (int_ack) begin
                m_req = 1'b0;
                nsvc[m_lvl] = 1'b1;
            end
        end else if (instr_end && !blk && win >= 0) begin
            m_req = 1'b1;
            m_src = win;
            m_lvl = wl;
            m_vec = 3 + 8 * win;
        end
        m_flag = nf;
        m_svc  = nsvc;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"}, int'(int_req), int'(m_req));
        if (m_req) chk({tag, ".vec"}, int'(int_vec), m_vec);
        chk({tag, ".flags"}, int'(tcon_flags), int'(m_flag));
        chk({tag, ".svc"}, int'(in_svc), int'(m_svc));
    endtask

    task automatic expect_out(input string tag, input int req, input int vec,
                              input int flags, input int svc);
        chk({tag, ".req"}, int'(int_req), req);
        if (req != 0) chk({tag, ".vec"}, int'(int_vec), vec);
        chk({tag, ".flags"}, int'(tcon_flags), flags);
        chk({tag, ".svc"}, int'(in_svc), svc);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) m_clock();
        else m_reset();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle_inputs();
        int0_n = 1'b1; int1_n = 1'b1; it0 = 1'b0; it1 = 1'b0;
        t0_ovf = 1'b0; t1_ovf = 1'b0; ri = 1'b0; ti = 1'b0;
        ie = 8'h00; ip = 5'h00; sw_clr = 4'h0;
        instr_end = 1'b0; int_ack = 1'b0; reti = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        chk("reset.vec", int'(int_vec), 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit pin;
        bit ack;
        bit rti;
        int req;
        int vec;
        int flags;
        int svc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Edge-triggered INT0: 3-cycle low pulse, request, acknowledge, return
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0,      0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 0, 0,      0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 0, 0,      0, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 0, 0,      1, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1, 16'h03, 1, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 0, 0,      0, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 0, 0,      0, 1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 0, 0,      0, 0};

        do_reset();
        it0 = 1'b1; ie = 8'h81; instr_end = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int0_n = tbl[k].pin; int_ack = tbl[k].ack; reti = tbl[k].rti;
            step("tbl");
            expect_out($sformatf("tbl%0d", k), tbl[k].req, tbl[k].vec, tbl[k].flags, tbl[k].svc);
        end

        // Simultaneous timer overflows: high TF1 first, TF0 after reti
        do_reset();
        ie = 8'h8A; ip = 5'h08; instr_end = 1'b1;
        step("tm");
        t0_ovf = 1'b1; t1_ovf = 1'b1;
        step("tm"); expect_out("tm.set", 0, 0, 4'b1010, 0);
        step("tm"); expect_out("tm.req1", 1, 16'h1B, 4'b1010, 0);
        int_ack = 1'b1; step("tm"); int_ack = 1'b0;
        expect_out("tm.ack1", 0, 0, 4'b0010, 2'b10);
        step("tm"); step("tm"); expect_out("tm.hold", 0, 0, 4'b0010, 2'b10);
        reti = 1'b1; step("tm"); reti = 1'b0; expect_out("tm.reti", 0, 0, 4'b0010, 0);
        step("tm"); expect_out("tm.blk", 0, 0, 4'b0010, 0);
        step("tm"); expect_out("tm.req2", 1, 16'h0B, 4'b0010, 0);
        int_ack = 1'b1; step("tm"); int_ack = 1'b0;
        expect_out("tm.ack2", 0, 0, 0, 2'b01);

        // Preemption by high INT1 while low TF0 is in service
        do_reset();
        ie = 8'h96; ip = 5'h04; it1 = 1'b1; instr_end = 1'b1;
        t0_ovf = 1'b1;
        step("pre"); step("pre"); expect_out("pre.req0", 1, 16'h0B, 4'b0010, 0);
        int_ack = 1'b1; step("pre"); int_ack = 1'b0; expect_out("pre.ack0", 0, 0, 0, 2'b01);
        ri = 1'b1; int1_n = 1'b0;
        for (int k = 0; k < 3; k++) step("pre");
        expect_out("pre.ie1", 0, 0, 4'b0100, 2'b01);
        step("pre"); expect_out("pre.req1", 1, 16'h13, 4'b0100, 2'b01);
        int_ack = 1'b1; step("pre"); int_ack = 1'b0; expect_out("pre.ack1", 0, 0, 0, 2'b11);
        reti = 1'b1; step("pre"); reti = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("pre");
            expect_out("pre.held", 0, 0, 0, 2'b01);
        end
        reti = 1'b1; step("pre"); reti = 1'b0; expect_out("pre.reti2", 0, 0, 0, 0);
        step("pre"); expect_out("pre.blk", 0, 0, 0, 0);
        step("pre"); expect_out("pre.ser", 1, 16'h23, 0, 0);
        int_ack = 1'b1; step("pre"); int_ack = 1'b0; ri = 1'b0;

        // Set beats software clear; EA low never requests
        do_reset();
        ie = 8'h02; instr_end = 1'b1;
        t0_ovf = 1'b1; sw_clr = 4'b0010;
        step("sc"); sw_clr = 4'b0000; expect_out("sc.win", 0, 0, 4'b0010, 0);
        for (int k = 0; k < 4; k++) begin
            step("sc");
            expect_out("sc.noea", 0, 0, 4'b0010, 0);
        end
        sw_clr = 4'b0010; step("sc"); sw_clr = 4'b0000; expect_out("sc.clr", 0, 0, 0, 0);

        // Level INT1 held low through ack, re-request after reti block
        do_reset();
        ie = 8'h84; instr_end = 1'b1; int1_n = 1'b0;
        for (int k = 0; k < 3; k++) step("lv");
        expect_out("lv.set", 0, 0, 4'b0100, 0);
        step("lv"); expect_out("lv.req", 1, 16'h13, 4'b0100, 0);
        int_ack = 1'b1; step("lv"); int_ack = 1'b0; expect_out("lv.ack", 0, 0, 4'b0100, 2'b01);
        step("lv"); step("lv"); expect_out("lv.wait", 0, 0, 4'b0100, 2'b01);
        reti = 1'b1; step("lv"); reti = 1'b0; expect_out("lv.reti", 0, 0, 4'b0100, 0);
        step("lv"); expect_out("lv.blk", 0, 0, 4'b0100, 0);
        step("lv"); expect_out("lv.rereq", 1, 16'h13, 4'b0100, 0);

        // Asynchronous reset while requesting
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst", 0, 0, 0, 0);
        chk("arst.vec", int'(int_vec), 0);
        m_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                ie  = 8'($urandom) | 8'h80;
                if ($urandom_range(0, 7) == 0) ie[7] = 1'b0;
                ip  = 5'($urandom);
                it0 = 1'($urandom);
                it1 = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0) int0_n = ~int0_n;
            if ($urandom_range(0, 7) == 0) int1_n = ~int1_n;
            if ($urandom_range(0, 5) == 0) t0_ovf = ~t0_ovf;
            if ($urandom_range(0, 5) == 0) t1_ovf = ~t1_ovf;
            ri        = ($urandom_range(0, 15) == 0);
            ti        = ($urandom_range(0, 19) == 0);
            sw_clr    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            instr_end = ($urandom_range(0, 3) != 0);
            int_ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            reti      = ($urandom_range(0, 9) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
